stage_sequencer: RTL and testbench



---
 rtl/stage_sequencer_pkg.sv | 27 ++
 rtl/stage_sequencer_rise_detector.sv | 23 ++
 rtl/stage_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared types for the stage sequencer: game-flow state enum and frame-counter sizing.
package stage_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    INIT        = 4'd1,
    PLAY        = 4'd2,
    PAUSED      = 4'd3,
    RESPAWN     = 4'd4,
    RESPAWN_RST = 4'd5,
    CLEAR       = 4'd6,
    WON         = 4'd7,
    LOST        = 4'd8
  } state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    if (max_val < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = $clog2(max_val + 32'sd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/stage_sequencer_rise_detector.sv
// One-bit rising-edge detector; the previous sample resets high so a level held
// through reset never looks like a fresh press.
module rise_detector (
  input  logic clk,
  input  logic resetN,
  input  logic level,
  output logic rise
);

  logic prev_r;

  // previous-sample register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= level;
    end
  end

  assign rise = level & ~prev_r;

endmodule

// File: rtl/stage_sequencer.sv
// Game-flow controller: sequences stages, tracks lives, and times respawn and
// stage transitions in video frames. Unit enables/soft resets are registered.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int                    NUM_STAGES        = 4,
  parameter int                    STAGE_WIDTH       = 3,
  parameter int                    NUM_LIVES         = 3,
  parameter int                    LIFE_WIDTH        = 2,
  parameter logic [NUM_STAGES-1:0] ASTERO_MASK       = 4'b0101,
  parameter int                    RESPAWN_FRAMES    = 60,
  parameter int                    TRANSITION_FRAMES = 90
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   start_game,
  input  logic                   pause,
  input  logic                   skip_stage,
  input  logic                   win_stage,
  input  logic                   player_died,
  output logic                   enable_player,
  output logic                   enable_monst,
  output logic                   enable_boss,
  output logic                   enable_astero,
  output logic                   resetN_player,
  output logic                   resetN_monst,
  output logic [STAGE_WIDTH-1:0] stage_num,
  output logic [LIFE_WIDTH-1:0]  lives,
  output logic                   paused,
  output logic                   game_won,
  output logic                   game_over
);

  localparam int MAX_FRAMES = (RESPAWN_FRAMES > TRANSITION_FRAMES) ? RESPAWN_FRAMES : TRANSITION_FRAMES;
  localparam int CNT_W      = cnt_width(MAX_FRAMES);
  localparam int MASK_W     = 2 ** STAGE_WIDTH;
  localparam logic [CNT_W-1:0] RESPAWN_LAST =
    CNT_W'((RESPAWN_FRAMES > 32'sd0) ? RESPAWN_FRAMES - 32'sd1 : 32'sd0);
  localparam logic [CNT_W-1:0] CLEAR_LAST =
    CNT_W'((TRANSITION_FRAMES > 32'sd0) ? TRANSITION_FRAMES - 32'sd1 : 32'sd0);
  localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(NUM_STAGES - 32'sd1);
  localparam logic [LIFE_WIDTH-1:0]  FULL_LIVES = LIFE_WIDTH'(NUM_LIVES);
  localparam logic [MASK_W-1:0]      MASK_EXT   = MASK_W'(ASTERO_MASK);

  state_e                 state_r, state_next_s;
  logic [STAGE_WIDTH-1:0] stage_r, stage_next_s;
  logic [LIFE_WIDTH-1:0]  lives_r, lives_next_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   done_s;
  logic                   start_rise_s, pause_rise_s, skip_rise_s;
  logic en_player_s, en_monst_s, en_boss_s, en_astero_s;
  logic rst_player_s, rst_monst_s, paused_s, won_s, over_s;

  rise_detector u_start_rise (.clk(clk), .resetN(resetN), .level(start_game), .rise(start_rise_s));
  rise_detector u_pause_rise (.clk(clk), .resetN(resetN), .level(pause),      .rise(pause_rise_s));
  rise_detector u_skip_rise  (.clk(clk), .resetN(resetN), .level(skip_stage), .rise(skip_rise_s));

  // frame-delay expiry; a zero-frame delay expires on the first cycle
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      RESPAWN: done_s = (RESPAWN_FRAMES == 32'sd0) || (startOfFrame && (cnt_r == RESPAWN_LAST));
      CLEAR:   done_s = (TRANSITION_FRAMES == 32'sd0) || (startOfFrame && (cnt_r == CLEAR_LAST));
      default: done_s = 1'b0;
    endcase
  end

  // next state, stage and lives
  always_comb begin
    state_next_s = state_r;
    stage_next_s = stage_r;
    lives_next_s = lives_r;
    case (state_r)
      IDLE: begin
        if (start_rise_s) state_next_s = INIT;
        else              state_next_s = IDLE;
      end
      INIT: state_next_s = PLAY;
      PLAY: begin
        if (player_died) begin
          if (lives_r <= LIFE_WIDTH'(1)) begin
            lives_next_s = '0;
            state_next_s = LOST;
          end else begin
            lives_next_s = lives_r - LIFE_WIDTH'(1);
            state_next_s = RESPAWN;
          end
        end else if (win_stage || skip_rise_s) begin
          if (stage_r == LAST_STAGE) state_next_s = WON;
          else                       state_next_s = CLEAR;
        end else if (pause_rise_s) begin
          state_next_s = PAUSED;
        end else begin
          state_next_s = PLAY;
        end
      end
      PAUSED: begin
        if (pause_rise_s) state_next_s = PLAY;
        else              state_next_s = PAUSED;
      end
      RESPAWN: begin
        if (done_s) state_next_s = RESPAWN_RST;
        else        state_next_s = RESPAWN;
      end
      RESPAWN_RST: state_next_s = PLAY;
      CLEAR: begin
        if (done_s) begin
          state_next_s = INIT;
          if (stage_r < LAST_STAGE) stage_next_s = stage_r + STAGE_WIDTH'(1);
          else                      stage_next_s = stage_r;
        end else begin
          state_next_s = CLEAR;
        end
      end
      WON, LOST: begin
        if (start_rise_s) begin
          state_next_s = INIT;
          stage_next_s = '0;
          lives_next_s = FULL_LIVES;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        stage_next_s = '0;
        lives_next_s = FULL_LIVES;
      end
    endcase
  end

  // output decode of the upcoming state so the flags come straight from flops
  always_comb begin
    en_player_s  = 1'b0;
    en_monst_s   = 1'b0;
    en_boss_s    = 1'b0;
    en_astero_s  = 1'b0;
    rst_player_s = 1'b0;
    rst_monst_s  = 1'b0;
    paused_s     = 1'b0;
    won_s        = 1'b0;
    over_s       = 1'b0;
    case (state_next_s)
      PLAY: begin
        rst_player_s = 1'b1;
        rst_monst_s  = 1'b1;
        en_player_s  = 1'b1;
        en_monst_s   = (stage_next_s != LAST_STAGE);
        en_boss_s    = (stage_next_s == LAST_STAGE);
        en_astero_s  = MASK_EXT[stage_next_s];
      end
      PAUSED: begin
        rst_player_s = 1'b1;
        rst_monst_s  = 1'b1;
        paused_s     = 1'b1;
      end
      RESPAWN, CLEAR: begin
        rst_player_s = 1'b1;
        rst_monst_s  = 1'b1;
      end
      RESPAWN_RST: rst_monst_s = 1'b1;
      WON: begin
        rst_player_s = 1'b1;
        rst_monst_s  = 1'b1;
        won_s        = 1'b1;
      end
      LOST: begin
        rst_player_s = 1'b1;
        rst_monst_s  = 1'b1;
        over_s       = 1'b1;
      end
      default: rst_player_s = 1'b0;
    endcase
  end

  // state, stage and lives registers
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r <= IDLE;
      stage_r <= '0;
      lives_r <= FULL_LIVES;
    end else begin
      state_r <= state_next_s;
      stage_r <= stage_next_s;
      lives_r <= lives_next_s;
    end
  end

  // frame counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_r <= '0;
    end else if (state_next_s != state_r) begin
      cnt_r <= '0;
    end else if (startOfFrame && ((state_r == RESPAWN) || (state_r == CLEAR))) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // registered unit controls and status flags
  always_ff @(posedge clk) begin
    if (!resetN) begin
      enable_player <= 1'b0;
      enable_monst  <= 1'b0;
      enable_boss   <= 1'b0;
      enable_astero <= 1'b0;
      resetN_player <= 1'b0;
      resetN_monst  <= 1'b0;
      paused        <= 1'b0;
      game_won      <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      enable_player <= en_player_s;
      enable_monst  <= en_monst_s;
      enable_boss   <= en_boss_s;
      enable_astero <= en_astero_s;
      resetN_player <= rst_player_s;
      resetN_monst  <= rst_monst_s;
      paused        <= paused_s;
      game_won      <= won_s;
      game_over     <= over_s;
    end
  end

  assign stage_num = stage_r;
  assign lives     = lives_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed vector table, hand sequences for corner
// cases, then random stimulus against a behavioural game-flow model.
module tb_stage_sequencer;

  localparam int NS = 4;
  localparam int NL = 3;
  localparam int RF = 2;
  localparam int TF = 3;
  localparam logic [3:0] MASK = 4'b0101;

  typedef struct packed {
    logic       en_p, en_m, en_b, en_a, rp, rm, paused, won, over;
    logic [2:0] stage;
    logic [1:0] lives;
  } outs_t;

  typedef struct {
    bit    rstn, st, pa, sk, wn, dd, sf;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic resetN = 1'b0, sof = 1'b0, start_game = 1'b0, pause = 1'b0;
  logic skip_stage = 1'b0, win_stage = 1'b0, player_died = 1'b0;
  logic enable_player, enable_monst, enable_boss, enable_astero;
  logic resetN_player, resetN_monst, paused, game_won, game_over;
  logic [2:0] stage_num;
  logic [1:0] lives;
  outs_t dut_o;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  stage_sequencer #(
    .NUM_STAGES(NS), .STAGE_WIDTH(3), .NUM_LIVES(NL), .LIFE_WIDTH(2),
    .ASTERO_MASK(MASK), .RESPAWN_FRAMES(RF), .TRANSITION_FRAMES(TF)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_game(start_game),
    .pause(pause), .skip_stage(skip_stage), .win_stage(win_stage),
    .player_died(player_died), .enable_player(enable_player),
    .enable_monst(enable_monst), .enable_boss(enable_boss),
    .enable_astero(enable_astero), .resetN_player(resetN_player),
    .resetN_monst(resetN_monst), .stage_num(stage_num), .lives(lives),
    .paused(paused), .game_won(game_won), .game_over(game_over)
  );

  assign dut_o = '{enable_player, enable_monst, enable_boss, enable_astero,
                   resetN_player, resetN_monst, paused, game_won, game_over,
                   stage_num, lives};

  // behavioural model: game mode, stage, lives and remaining frames of a delay
  localparam int M_IDLE = 0, M_INIT = 1, M_PLAY = 2, M_PAUSE = 3, M_DEAD = 4,
                 M_REVIVE = 5, M_CLEAR = 6, M_WON = 7, M_LOST = 8;
  int m_mode = M_IDLE, m_stage = 0, m_lives = NL, m_left = 0;
  bit m_ps = 1'b1, m_pp = 1'b1, m_pk = 1'b1;

  function automatic outs_t model_outs();
    outs_t o;
    bit run, units_up;
    run      = (m_mode == M_PLAY);
    units_up = !(m_mode == M_IDLE || m_mode == M_INIT);
    o.en_p   = run;
    o.en_m   = run && (m_stage != NS - 1);
    o.en_b   = run && (m_stage == NS - 1);
    o.en_a   = run && MASK[m_stage];
    o.rp     = units_up && (m_mode != M_REVIVE);
    o.rm     = units_up;
    o.paused = (m_mode == M_PAUSE);
    o.won    = (m_mode == M_WON);
    o.over   = (m_mode == M_LOST);
    o.stage  = 3'(m_stage);
    o.lives  = 2'(m_lives);
    return o;
  endfunction

  task automatic model_step();
    bit se, pe, ke;
    if (!resetN) begin
      m_mode = M_IDLE; m_stage = 0; m_lives = NL;
      m_ps = 1'b1; m_pp = 1'b1; m_pk = 1'b1;
    end else begin
      se = start_game && !m_ps;
      pe = pause && !m_pp;
      ke = skip_stage && !m_pk;
      case (m_mode)
        M_IDLE:   if (se) m_mode = M_INIT;
        M_INIT:   m_mode = M_PLAY;
        M_PLAY: begin
          if (player_died) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) m_mode = M_LOST;
            else begin m_mode = M_DEAD; m_left = RF; end
          end else if (win_stage || ke) begin
            if (m_stage == NS - 1) m_mode = M_WON;
            else begin m_mode = M_CLEAR; m_left = TF; end
          end else if (pe) m_mode = M_PAUSE;
        end
        M_PAUSE:  if (pe) m_mode = M_PLAY;
        M_DEAD: begin
          if (sof) m_left--;
          if (m_left <= 0) m_mode = M_REVIVE;
        end
        M_REVIVE: m_mode = M_PLAY;
        M_CLEAR: begin
          if (sof) m_left--;
          if (m_left <= 0) begin
            m_mode = M_INIT;
            if (m_stage < NS - 1) m_stage++;
          end
        end
        default: if (se) begin m_mode = M_INIT; m_stage = 0; m_lives = NL; end
      endcase
      m_ps = start_game; m_pp = pause; m_pk = skip_stage;
    end
  endtask

  task automatic cyc(input bit rstn, st, pa, sk, wn, dd, sf);
    outs_t e;
    @(negedge clk);
    resetN = rstn; start_game = st; pause = pa; skip_stage = sk;
    win_stage = wn; player_died = dd; sof = sf;
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
    e = model_outs();
    checks++;
    if (dut_o !== e) begin
      failures++;
      $display("FAIL model cycle=%0d got=%b want=%b", cyc_n, dut_o, e);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic outs_t mk(bit p, m, a, rp, rm, int stg, int lv);
    outs_t o;
    o = '0;
    o.en_p = p; o.en_m = m; o.en_a = a; o.rp = rp; o.rm = rm;
    o.stage = 3'(stg); o.lives = 2'(lv);
    return o;
  endfunction

  vec_t vecs[$];

  task automatic add(input bit rstn, st, pa, sk, wn, dd, sf, input outs_t e);
    vec_t v;
    v.rstn = rstn; v.st = st; v.pa = pa; v.sk = sk; v.wn = wn; v.dd = dd; v.sf = sf;
    v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    // rst st pa sk wn dd sf : expected outputs after the edge
    add(0,1,0,0,0,0,0, mk(0,0,0,0,0,0,3));  // reset, start held
    add(1,1,0,0,0,0,0, mk(0,0,0,0,0,0,3));  // held start: no edge
    add(1,0,0,0,0,0,0, mk(0,0,0,0,0,0,3));
    add(1,1,0,0,0,0,0, mk(0,0,0,0,0,0,3));  // INIT
    add(1,1,0,0,0,0,0, mk(1,1,1,1,1,0,3));  // PLAY stage 0
    add(1,0,0,0,1,0,0, mk(0,0,0,1,1,0,3));  // CLEAR
    add(1,0,0,0,0,0,1, mk(0,0,0,1,1,0,3));
    add(1,0,0,0,0,0,0, mk(0,0,0,1,1,0,3));
    add(1,0,0,0,0,0,1, mk(0,0,0,1,1,0,3));
    add(1,0,0,0,0,0,1, mk(0,0,0,0,0,1,3));  // INIT stage 1
    add(1,0,0,0,0,0,0, mk(1,1,0,1,1,1,3));  // PLAY, no asteroids
    add(1,0,0,0,0,1,0, mk(0,0,0,1,1,1,2));  // RESPAWN
    add(1,0,0,0,0,1,1, mk(0,0,0,1,1,1,2));  // death ignored
    add(1,0,0,0,0,0,1, mk(0,0,0,0,1,1,2));  // player reset only
    add(1,0,0,0,0,0,0, mk(1,1,0,1,1,1,2));  // PLAY
    foreach (vecs[i]) begin
      cyc(vecs[i].rstn, vecs[i].st, vecs[i].pa, vecs[i].sk, vecs[i].wn, vecs[i].dd, vecs[i].sf);
      checks++;
      if (dut_o !== vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d got=%b want=%b", i, dut_o, vecs[i].exp);
      end
    end

    // pause holds off a win; resume acts on it
    cyc(1,0,1,0,0,0,0); chk("pause_on", paused, 1); chk("pause_en", enable_player, 0);
    cyc(1,0,1,0,1,0,0); chk("pause_win", paused, 1);
    cyc(1,0,0,0,1,0,0); chk("pause_hold", paused, 1);
    cyc(1,0,1,0,1,0,0); chk("resume", enable_player, 1);
    cyc(1,0,1,0,1,0,0); chk("resume_clear", enable_player, 0); chk("resume_clear_p", paused, 0);
    repeat (3) cyc(1,0,0,0,0,0,1);
    cyc(1,0,0,0,0,0,0); chk("stage2", stage_num, 2); chk("stage2_ast", enable_astero, 1);

    // death beats win in the same cycle
    cyc(1,0,0,0,1,1,0); chk("prio_lives", lives, 1); chk("prio_en", enable_player, 0);
    cyc(1,0,0,0,0,0,1);
    cyc(1,0,0,0,0,0,1); chk("revive_rp", resetN_player, 0); chk("revive_rm", resetN_monst, 1);
    cyc(1,0,0,0,0,0,0); chk("revive_play", enable_player, 1);
    cyc(1,0,0,0,0,1,0); chk("lost_lives", lives, 0); chk("lost_flag", game_over, 1);
    cyc(1,0,0,0,0,1,0); chk("no_underflow", lives, 0);
    cyc(1,1,0,0,0,0,0); chk("restart_lives", lives, 3); chk("restart_stage", stage_num, 0);
    cyc(1,0,0,0,0,0,0);

    // skip to the boss stage, then skip it
    for (int s = 0; s < 3; s++) begin
      cyc(1,0,0,1,0,0,0);
      cyc(1,0,0,0,0,0,1);
      cyc(1,0,0,0,0,0,1);
      cyc(1,0,0,0,0,0,1);
      cyc(1,0,0,0,0,0,0);
    end
    chk("boss_stage", stage_num, 3); chk("boss_en", enable_boss, 1); chk("boss_monst", enable_monst, 0);
    cyc(1,0,0,1,0,0,0); chk("won", game_won, 1); chk("won_boss", enable_boss, 0);
    cyc(1,1,0,1,0,0,0); chk("won_restart", stage_num, 0);
    cyc(1,0,0,0,0,0,0);

    // reset in the middle of a respawn
    cyc(1,0,0,0,0,1,0); chk("mid_dead", lives, 2);
    cyc(0,0,0,0,0,0,1); chk("mid_rst_lives", lives, 3); chk("mid_rst_rp", resetN_player, 0);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      bit rn, st, pa, sk;
      rn = ($urandom_range(0, 499) != 0);
      st = ($urandom_range(0, 19) == 0) ? !start_game : start_game;
      pa = ($urandom_range(0, 14) == 0) ? !pause : pause;
      sk = ($urandom_range(0, 39) == 0) ? !skip_stage : skip_stage;
      cyc(rn, st, pa, sk, $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
